phase_sequencer: RTL and testbench
==================================

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 The block SHALL have parameter PRELIM_SEC, default 3, meaning the prelim period length in seconds (legal range 1..15).
REQ-002 The block SHALL have parameter GAME_SEC, default 10, meaning the symbol-generation period length in seconds (legal range 1..15).
REQ-003 The block SHALL have parameter ANSWER_SEC, default 8, meaning the user-count period length in seconds (legal range 1..15).
REQ-004 The block SHALL have parameter POST_SEC, default 3, meaning the result-display period length in seconds (legal range 1..15).
REQ-005 The block SHALL have parameter MAX_LEVEL, default 9, meaning the final level; clearing it SHALL enter WIN.
REQ-006 The block SHALL have parameter TOLERANCE, default 0, meaning the largest |user - actual| difference that passes a level.
REQ-007 The block SHALL have port Clk100M, input, 1 bit: the sole clock; all logic is on its rising edge.
REQ-008 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-009 The block SHALL have port tick1Hz, input, 1 bit: one-cycle pulse, synchronous to Clk100M, once per second.
REQ-010 The block SHALL have port start, input, 1 bit: one-cycle user start pulse.
REQ-011 The block SHALL have port userDone, input, 1 bit: one-cycle pulse meaning the user ends the answer period early.
REQ-012 The block SHALL have port difference, input, 5 bits: the score magnitude, valid while in JUDGE.
REQ-013 The block SHALL have port pre/game/answer/post, output, 1 bit each: one-hot period flags, all 0 outside those periods.
REQ-014 The block SHALL have port startGen, stopGen and stopCount, output, 1 bit each: one-cycle control pulses.
REQ-015 The block SHALL have port incLevel, output, 1 bit: one-cycle pulse on a passed level.
REQ-016 The block SHALL have port curLevel, output, 4 bits: the current level, 1..MAX_LEVEL.
REQ-017 The block SHALL have port secLeft, output, 4 bits: the seconds remaining in the current timed period, 0 otherwise.
REQ-018 The block SHALL have port lose and win, output, 1 bit each: game-over levels.

Function
REQ-019 The state machine SHALL have the states IDLE, PRELIM, GAME, ANSWER, POST, JUDGE, WIN and LOSE, with all state and outputs registered.
REQ-020 A start pulse in IDLE, WIN or LOSE SHALL cause the next state to be PRELIM, with secLeft=PRELIM_SEC and curLevel=1 (curLevel only from WIN/LOSE; IDLE already has 1).
REQ-021 The block SHALL ignore start while in PRELIM, GAME, ANSWER, POST or JUDGE.
REQ-022 In a timed state, each tick1Hz SHALL decrement secLeft.
REQ-023 When tick1Hz arrives with secLeft==1, the block SHALL advance to the next state on that edge: PRELIM->GAME->ANSWER->POST->JUDGE, and load the new period's *_SEC value (0 for JUDGE).
REQ-024 startGen SHALL be high for exactly the first cycle of GAME.
REQ-025 stopGen SHALL be high for exactly the first cycle of ANSWER.
REQ-026 stopCount SHALL be high for exactly the first cycle of POST.
REQ-027 JUDGE SHALL last exactly 1 cycle and SHALL sample difference on that cycle.
REQ-028 In JUDGE, if difference<=TOLERANCE and curLevel<MAX_LEVEL, the block SHALL pulse incLevel, increment curLevel and go to PRELIM.
REQ-029 In JUDGE, if difference<=TOLERANCE and curLevel==MAX_LEVEL, the block SHALL pulse incLevel, hold curLevel and go to WIN.
REQ-030 In JUDGE, if difference>TOLERANCE, the block SHALL go to LOSE.
REQ-031 lose SHALL be 1 exactly while in LOSE, and win SHALL be 1 exactly while in WIN.
REQ-032 The period flags SHALL equal the registered state with no extra latency.
REQ-033 curLevel SHALL never wrap and never exceed MAX_LEVEL.
REQ-034 When tick1Hz and userDone coincide, userDone SHALL take priority.

Reset
REQ-035 Asserting reset low SHALL immediately force state=IDLE, curLevel=1, secLeft=0 and every other output to 0.
REQ-036 Reset SHALL be effective in any state, including mid-period.
REQ-037 After reset deasserts, the block SHALL remain in IDLE until a start pulse.

Configuration
REQ-038 With EARLY_ANSWER_EN defined, userDone in ANSWER SHALL move the block to POST on the next edge, pulse stopCount and load POST_SEC.
REQ-039 Without EARLY_ANSWER_EN, the block SHALL ignore userDone entirely and omit its logic.

Verification
REQ-040 Reset, start, then pulse tick1Hz repeatedly -> PRELIM lasts 3 ticks, GAME 10, ANSWER 8, POST 3; startGen, stopGen and stopCount each 1 cycle at their entries.
REQ-041 At JUDGE with difference=0 at level 1 -> incLevel pulse, curLevel=2, pre=1, secLeft=3.
REQ-042 At JUDGE with difference=3 and TOLERANCE=0 -> lose=1 and held; start -> PRELIM with curLevel=1.
REQ-043 Pass at level 9 -> win=1 and curLevel stays 9; start pulses during GAME are ignored.
REQ-044 With EARLY_ANSWER_EN, userDone together with tick1Hz at ANSWER secLeft=5 -> next cycle post=1, secLeft=3, stopCount=1 for 1 cycle.
REQ-045 Assert reset low while secLeft=4 in GAME -> same-cycle outputs all 0 and curLevel=1; after release, the block stays in IDLE.

Source files
------------

// File: rtl/phase_sequencer_if.sv
// Handshake and status bundle between the game controller and the phase sequencer.
interface phase_sequencer_if;
    logic       tick1Hz;
    logic       start;
    logic       userDone;
    logic [4:0] difference;
    logic       pre, game, answer, post;
    logic       startGen, stopGen, stopCount, incLevel;
    logic [3:0] curLevel, secLeft;
    logic       lose, win;

    modport master (
        output tick1Hz, start, userDone, difference,
        input  pre, game, answer, post, startGen, stopGen, stopCount, incLevel,
        input  curLevel, secLeft, lose, win
    );
    modport slave (
        input  tick1Hz, start, userDone, difference,
        output pre, game, answer, post, startGen, stopGen, stopCount, incLevel,
        output curLevel, secLeft, lose, win
    );
endinterface

// File: rtl/phase_sequencer.sv
// Level/phase sequencer: PRELIM -> GAME -> ANSWER -> POST -> JUDGE per level, ending in WIN or LOSE.
// Optional macro EARLY_ANSWER_EN lets userDone cut the ANSWER period short.
module phase_sequencer #(
    parameter int PRELIM_SEC = 3,
    parameter int GAME_SEC   = 10,
    parameter int ANSWER_SEC = 8,
    parameter int POST_SEC   = 3,
    parameter int MAX_LEVEL  = 9,
    parameter int TOLERANCE  = 0
) (
    input logic               Clk100M,
    input logic               reset,
    phase_sequencer_if.slave  bus
);
    localparam logic [3:0] PRE_S  = PRELIM_SEC[3:0];
    localparam logic [3:0] GAME_S = GAME_SEC[3:0];
    localparam logic [3:0] ANS_S  = ANSWER_SEC[3:0];
    localparam logic [3:0] POST_S = POST_SEC[3:0];
    localparam logic [3:0] MAX_L  = MAX_LEVEL[3:0];
    localparam logic [4:0] TOL    = TOLERANCE[4:0];

    typedef enum logic [2:0] {
        S_IDLE, S_PRELIM, S_GAME, S_ANSWER, S_POST, S_JUDGE, S_WIN, S_LOSE
    } state_t;

    state_t     state, state_nx;
    logic [3:0] sec_q, sec_d, lvl_q, lvl_d;
    logic       start_gen_q, stop_gen_q, stop_count_q, inc_level_q;
    logic       start_gen_d, stop_gen_d, stop_count_d, inc_level_d;
    logic       last_tick, pass, early;

    assign last_tick = bus.tick1Hz && (sec_q == 4'd1);
    assign pass      = (bus.difference <= TOL);
`ifdef EARLY_ANSWER_EN
    assign early = bus.userDone;
`else
    assign early = 1'b0;
`endif

    // State register, including all registered outputs
    always_ff @(posedge Clk100M or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            sec_q        <= 4'd0;
            lvl_q        <= 4'd1;
            start_gen_q  <= 1'b0;
            stop_gen_q   <= 1'b0;
            stop_count_q <= 1'b0;
            inc_level_q  <= 1'b0;
        end else begin
            state        <= state_nx;
            sec_q        <= sec_d;
            lvl_q        <= lvl_d;
            start_gen_q  <= start_gen_d;
            stop_gen_q   <= stop_gen_d;
            stop_count_q <= stop_count_d;
            inc_level_q  <= inc_level_d;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_WIN, S_LOSE: if (bus.start) state_nx = S_PRELIM;
            S_PRELIM: if (last_tick) state_nx = S_GAME;
            S_GAME:   if (last_tick) state_nx = S_ANSWER;
            S_ANSWER: if (early || last_tick) state_nx = S_POST;
            S_POST:   if (last_tick) state_nx = S_JUDGE;
            S_JUDGE: begin
                if (!pass)              state_nx = S_LOSE;
                else if (lvl_q < MAX_L) state_nx = S_PRELIM;
                else                    state_nx = S_WIN;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Next values of the registered outputs: entry pulses and period reloads on a state change
    always_comb begin
        sec_d        = sec_q;
        lvl_d        = lvl_q;
        start_gen_d  = 1'b0;
        stop_gen_d   = 1'b0;
        stop_count_d = 1'b0;
        inc_level_d  = 1'b0;
        if (state_nx != state) begin
            case (state_nx)
                S_PRELIM: sec_d = PRE_S;
                S_GAME:   begin sec_d = GAME_S; start_gen_d  = 1'b1; end
                S_ANSWER: begin sec_d = ANS_S;  stop_gen_d   = 1'b1; end
                S_POST:   begin sec_d = POST_S; stop_count_d = 1'b1; end
                default:  sec_d = 4'd0;
            endcase
        end else if (bus.tick1Hz && sec_q != 4'd0) begin
            sec_d = sec_q - 4'd1;
        end
        if ((state == S_IDLE || state == S_WIN || state == S_LOSE) && bus.start)
            lvl_d = 4'd1;
        if (state == S_JUDGE && pass) begin
            inc_level_d = 1'b1;
            if (lvl_q < MAX_L) lvl_d = lvl_q + 4'd1;
        end
    end

    assign bus.pre       = (state == S_PRELIM);
    assign bus.game      = (state == S_GAME);
    assign bus.answer    = (state == S_ANSWER);
    assign bus.post      = (state == S_POST);
    assign bus.lose      = (state == S_LOSE);
    assign bus.win       = (state == S_WIN);
    assign bus.startGen  = start_gen_q;
    assign bus.stopGen   = stop_gen_q;
    assign bus.stopCount = stop_count_q;
    assign bus.incLevel  = inc_level_q;
    assign bus.curLevel  = lvl_q;
    assign bus.secLeft   = sec_q;
endmodule

// File: tb/tb_phase_sequencer.sv
// Directed + randomized bench for phase_sequencer against a phase-list reference model.
module tb_phase_sequencer;
`ifdef EARLY_ANSWER_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam int MAXL = 9;
    localparam int TOL  = 0;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    phase_sequencer_if bus ();
    phase_sequencer dut (.Clk100M(clk), .reset(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    // Model: phase 0 idle, 1..4 timed periods, 5 judge, 6 win, 7 lose
    int dur [1:4] = '{3, 10, 8, 3};
    int m_p, m_sec, m_lvl;
    bit m_sg, m_sp, m_sc, m_inc;

    task automatic model_reset();
        m_p = 0; m_sec = 0; m_lvl = 1;
        m_sg = 0; m_sp = 0; m_sc = 0; m_inc = 0;
    endtask

    task automatic model_step(input bit tk, input bit st, input bit ud, input int diff);
        int np;
        np = m_p;
        m_inc = 0;
        if (m_p == 0 || m_p >= 6) begin
            if (st) begin np = 1; m_lvl = 1; m_sec = dur[1]; end
        end else if (m_p == 5) begin
            if (diff <= TOL) begin
                m_inc = 1;
                if (m_lvl < MAXL) begin m_lvl++; np = 1; m_sec = dur[1]; end
                else begin np = 6; m_sec = 0; end
            end else begin
                np = 7; m_sec = 0;
            end
        end else if (EARLY && m_p == 3 && ud) begin
            np = 4; m_sec = dur[4];
        end else if (tk) begin
            m_sec--;
            if (m_sec == 0) begin
                np = m_p + 1;
                m_sec = (np <= 4) ? dur[np] : 0;
            end
        end
        m_sg = (np == 2 && m_p != 2);
        m_sp = (np == 3 && m_p != 3);
        m_sc = (np == 4 && m_p != 4);
        m_p = np;
    endtask

    function automatic logic [17:0] model_vec();
        return {m_p == 1, m_p == 2, m_p == 3, m_p == 4, m_sg, m_sp, m_sc, m_inc,
                4'(m_lvl), 4'(m_sec), m_p == 7, m_p == 6};
    endfunction

    function automatic logic [17:0] dut_vec();
        return {bus.pre, bus.game, bus.answer, bus.post, bus.startGen, bus.stopGen,
                bus.stopCount, bus.incLevel, bus.curLevel, bus.secLeft, bus.lose, bus.win};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit tk, input bit st, input bit ud, input logic [4:0] df);
        bus.tick1Hz = tk; bus.start = st; bus.userDone = ud; bus.difference = df;
        @(posedge clk);
        model_step(tk, st, ud, int'(df));
        #1;
        bus.tick1Hz = 1'b0; bus.start = 1'b0; bus.userDone = 1'b0;
        chk("cycle", 32'(dut_vec()), 32'(model_vec()));
    endtask

    task automatic ticks_until(input int p, input int s);
        for (int i = 0; i < 64 && !(m_p == p && m_sec == s); i++) cycle(1'b1, 1'b0, 1'b0, 5'd0);
        chk("reach_timeout", 32'(m_p == p && m_sec == s), 32'd1);
    endtask

    // Random ticks, ignored starts and optional userDone until JUDGE, then judge with diff
    task automatic play_level(input logic [4:0] diff, input bit use_ud);
        int g;
        for (g = 0; g < 400 && m_p != 5; g++)
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                  use_ud && ($urandom_range(0, 15) == 0), 5'($urandom_range(0, 31)));
        chk("judge_timeout", 32'(m_p), 32'd5);
        cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, diff);
    endtask

    initial begin
        model_reset();
        bus.tick1Hz = 0; bus.start = 0; bus.userDone = 0; bus.difference = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 32'(dut_vec()), 32'(model_vec()));
        rst_n = 1'b1;
        repeat (4) cycle(1'b1, 1'b0, 1'b1, 5'd0);
        chk("idle_hold_pre", 32'(bus.pre), 32'd0);

        // Level 1, timing of each period
        cycle(1'b0, 1'b1, 1'b0, 5'd0);
        chk("start_pre", 32'({bus.pre, bus.secLeft, bus.curLevel}), 32'({1'b1, 4'd3, 4'd1}));
        cycle(1'b1, 1'b0, 1'b0, 5'd0);
        cycle(1'b1, 1'b0, 1'b0, 5'd0);
        chk("prelim_2ticks", 32'({bus.pre, bus.secLeft}), 32'({1'b1, 4'd1}));
        cycle(1'b1, 1'b0, 1'b0, 5'd0);
        chk("game_entry", 32'({bus.game, bus.startGen, bus.secLeft}), 32'({1'b1, 1'b1, 4'd10}));
        cycle(1'b0, 1'b1, 1'b0, 5'd0);
        chk("startgen_1cyc", 32'({bus.game, bus.startGen}), 32'({1'b1, 1'b0}));
        ticks_until(3, 8);
        chk("answer_entry", 32'({bus.answer, bus.stopGen, bus.secLeft}), 32'({1'b1, 1'b1, 4'd8}));
        ticks_until(4, 3);
        chk("post_entry", 32'({bus.post, bus.stopCount, bus.secLeft}), 32'({1'b1, 1'b1, 4'd3}));
        ticks_until(5, 0);
        cycle(1'b0, 1'b0, 1'b0, 5'd0);
        chk("judge_pass", 32'({bus.incLevel, bus.curLevel, bus.pre, bus.secLeft}),
            32'({1'b1, 4'd2, 1'b1, 4'd3}));

        // Levels 2..9, ending in WIN
        for (int lv = 2; lv <= MAXL; lv++) play_level(5'(TOL), 1'b0);
        chk("win", 32'({bus.win, bus.curLevel, bus.incLevel}), 32'({1'b1, 4'd9, 1'b1}));
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 5'd0);
        chk("win_held", 32'({bus.win, bus.curLevel}), 32'({1'b1, 4'd9}));

        // Fail a level
        cycle(1'b0, 1'b1, 1'b0, 5'd0);
        chk("restart_from_win", 32'({bus.pre, bus.curLevel}), 32'({1'b1, 4'd1}));
        play_level(5'd3, 1'b0);
        chk("lose", 32'({bus.lose, bus.incLevel}), 32'({1'b1, 1'b0}));
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 5'd0);
        chk("lose_held", 32'(bus.lose), 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 5'd0);
        chk("restart_from_lose", 32'({bus.pre, bus.curLevel, bus.secLeft}), 32'({1'b1, 4'd1, 4'd3}));

        // userDone coinciding with tick at ANSWER secLeft=5
        ticks_until(3, 5);
        cycle(1'b1, 1'b0, 1'b1, 5'd0);
        chk("early_post", 32'({bus.post, bus.secLeft, bus.stopCount}),
            EARLY ? 32'({1'b1, 4'd3, 1'b1}) : 32'({1'b0, 4'd4, 1'b0}));
        cycle(1'b0, 1'b0, 1'b0, 5'd0);
        chk("early_sc_1cyc", 32'(bus.stopCount), 32'd0);
        play_level(5'(TOL), 1'b1);
        play_level(5'(TOL), 1'b1);

        // Reset in GAME with secLeft=4
        ticks_until(2, 4);
        chk("game_sec4", 32'({bus.game, bus.secLeft}), 32'({1'b1, 4'd4}));
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_reset", 32'(dut_vec()), 32'({14'd0, 4'd0} | 18'(1 << 6)));
        chk("async_reset_model", 32'(dut_vec()), 32'(model_vec()));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) cycle(1'b1, 1'b0, 1'b0, 5'd0);
        chk("idle_after_reset", 32'({bus.pre, bus.game, bus.secLeft, bus.curLevel}),
            32'({1'b0, 1'b0, 4'd0, 4'd1}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
